zero_pad_stream: RTL and testbench
==================================

Name: zero_pad_stream

Overview:
- Streaming zero-padding stage that sits directly downstream of the 3x3/stride-2 max-pooling stage and feeds the next convolution's window generator.
- Takes a raster-order stream of IMG_WIDHT x IMG_HEIGHT 32-bit words (IEEE-754 single) on a valid-only interface.
- Emits the same frame surrounded by PAD rows/columns of 32'h0000_0000, giving (IMG_WIDHT+2*PAD) x (IMG_HEIGHT+2*PAD) words.
- An internal FIFO absorbs input arriving while pad words are being emitted.

Parameters:
- DATA_WIDHT, 32: word width in bits.
- IMG_WIDHT, 21: input columns per row (the 44x44 / 3x3 / stride-2 pool output).
- IMG_HEIGHT, 21: input rows per frame.
- PAD, 1: pad width on each side. Legal range 0..3.
- FIFO_DEPTH, 32: input FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- Data_In, input, DATA_WIDHT: input pixel word.
- Valid_In, input, 1: Data_In is valid this cycle. The block has no back-pressure.
- Data_Out, output, DATA_WIDHT: padded-stream word; registered.
- Valid_Out, output, 1: Data_Out is valid this cycle; registered.
- Frame_Done, output, 1: one-cycle pulse coincident with the last output word of a frame.
- Overflow, output, 1: sticky flag; an input word was dropped.

Behaviour:
- Reset (asynchronous, rst=1):
  - Data_Out=0, Valid_Out=0, Frame_Done=0, Overflow=0.
  - FIFO empty; FSM in IDLE; row and column counters at 0.
  - Asserting rst mid-frame discards the frame in progress and any FIFO contents.
- FIFO:
  - Push on Valid_In whenever not full.
  - Push while full with no pop that cycle: drop the word and set Overflow. Overflow holds until rst.
  - Push and pop in the same cycle while full is legal: count unchanged, nothing dropped.
  - Pop and push in the same cycle while empty is not allowed; the pop waits for the registered count.
- FSM states: IDLE, PAD_TOP, ROW_LEFT, ROW_DATA, ROW_RIGHT, PAD_BOT.
  - IDLE: leave when FIFO non-empty. Go to PAD_TOP if PAD>0, otherwise ROW_DATA (with PAD=0, ROW_LEFT and ROW_RIGHT are also skipped).
  - PAD_TOP: emit PAD*(IMG_WIDHT+2*PAD) zero words back-to-back, one per cycle, then go to ROW_LEFT.
  - ROW_LEFT: emit PAD zeros, then go to ROW_DATA.
  - ROW_DATA: each cycle the FIFO is non-empty, pop and emit the head word. When it is empty, stall with Valid_Out=0; counters hold.
    - After IMG_WIDHT words, go to ROW_RIGHT.
  - ROW_RIGHT: emit PAD zeros.
    - If the row counter is below IMG_HEIGHT-1: increment it and go to ROW_LEFT.
    - Otherwise go to PAD_BOT.
  - PAD_BOT: emit PAD*(IMG_WIDHT+2*PAD) zeros, then go to IDLE.
- Pad words are never stalled; only ROW_DATA waits on input.
- Frame_Done=1 in the cycle Valid_Out carries the final word. That word is the last bottom-pad zero, or the last data word when PAD=0.
- Back-to-back frames:
  - Input for frame N+1 may arrive during any phase of frame N; it is queued in the FIFO.
  - IDLE with a non-empty FIFO starts the next frame on the next edge, so there is exactly 1 idle output cycle between frames.
- Latency: the first output word of a frame (pad zero, or data if PAD=0) is valid 2 cycles after the first Valid_In of that frame, provided the FSM was in IDLE.
- Throughput:
  - The source's sustained input rate must not exceed IMG_WIDHT/(IMG_WIDHT+2*PAD) words per cycle over any window longer than FIFO_DEPTH.
  - Exceeding it sets Overflow. Corrupted frame alignment after overflow is acceptable; recovery is by rst.
- Counters:
  - Column counter width: clog2(IMG_WIDHT+2*PAD+1).
  - Row counter width: clog2(IMG_HEIGHT+1).
  - No wrap occurs before the FSM resets them at phase boundaries.

Test Plan:
- W=H=3, PAD=1, inputs 1..9 on consecutive cycles:
  - 25 output words: rows 0 and 4 all zero; rows 1-3 = 0,a,b,c,0.
  - First Valid_Out 2 cycles after the first Valid_In.
  - Frame_Done on word 25 only; Overflow stays 0.
- Same frame with a 5-cycle gap inserted before input 5:
  - Valid_Out drops only in ROW_DATA; the word sequence is identical to the first scenario.
- Two frames streamed back-to-back at 3 words per 5 cycles:
  - 50 output words with exactly 1 idle cycle between frames.
  - Frame_Done pulses twice; Overflow=0.
- FIFO_DEPTH=4, W=H=3, PAD=3: 9 inputs on consecutive cycles.
  - Overflow rises on the first dropped push and remains 1.
  - rst returns all outputs to 0 asynchronously, without waiting for clk.
- PAD=0, W=H=3: output equals input with no zeros inserted; Frame_Done coincides with the 9th data word.
- Assert rst in the middle of the second data row:
  - Outputs go to 0 immediately.
  - A fresh frame applied afterwards produces a correct 25-word output.

Source files
------------

// File: rtl/zero_pad_stream.sv
// zero_pad_stream: wraps a raster-order frame in PAD rings of zero words.
// Input words are queued in a small FIFO so the source can keep streaming
// while pad words go out; only the data part of a row ever waits on input.
// Each emitting state drives the output registers on the edge that leaves
// it, so IDLE always costs one empty output cycle between frames.
module zero_pad_stream #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDHT  = 21,
    parameter int IMG_HEIGHT = 21,
    parameter int PAD        = 1,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done,
    output logic                  Overflow
);

    localparam int ROW_LEN  = IMG_WIDHT + 2 * PAD;
    localparam int COL_W    = $clog2(ROW_LEN + 1);
    // pad rows reuse the row counter, so it must also be able to reach PAD-1
    localparam int ROW_SPAN = (IMG_HEIGHT > PAD) ? IMG_HEIGHT : PAD;
    localparam int ROW_W    = $clog2(ROW_SPAN + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = AW + 1;

    localparam logic [COL_W-1:0]      COL_ZERO     = COL_W'(0);
    localparam logic [COL_W-1:0]      COL_ONE      = COL_W'(1);
    localparam logic [COL_W-1:0]      COL_LINE_END = COL_W'(ROW_LEN - 1);
    localparam logic [COL_W-1:0]      COL_DATA_END = COL_W'(IMG_WIDHT - 1);
    localparam logic [COL_W-1:0]      COL_PAD_END  = COL_W'((PAD > 0) ? PAD - 1 : 0);
    localparam logic [ROW_W-1:0]      ROW_ZERO     = ROW_W'(0);
    localparam logic [ROW_W-1:0]      ROW_ONE      = ROW_W'(1);
    localparam logic [ROW_W-1:0]      ROW_PAD_END  = ROW_W'((PAD > 0) ? PAD - 1 : 0);
    localparam logic [ROW_W-1:0]      ROW_IMG_END  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [AW-1:0]         PTR_ZERO     = AW'(0);
    localparam logic [AW-1:0]         PTR_ONE      = AW'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDHT-1:0] ZERO_WORD    = DATA_WIDHT'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAD_TOP   = 3'd1,
        ROW_LEFT  = 3'd2,
        ROW_DATA  = 3'd3,
        ROW_RIGHT = 3'd4,
        PAD_BOT   = 3'd5
    } state_t;

    state_t                  state_r;
    logic [COL_W-1:0]        col_r;
    logic [ROW_W-1:0]        row_r;
    logic [DATA_WIDHT-1:0]   data_out_r;
    logic                    valid_out_r;
    logic                    frame_done_r;
    logic                    overflow_r;

    logic [DATA_WIDHT-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    fifo_empty_s;
    logic                    fifo_full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;

    // FIFO handshake: pops see only the registered count, pushes need room or a pop
    always_comb begin
        fifo_empty_s = (count_r == CNT_ZERO);
        fifo_full_s  = (count_r == CNT_FULL);
        if ((state_r == ROW_DATA) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (Valid_In && (!fifo_full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (Valid_In && fifo_full_s && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // FIFO storage; entries are meaningless until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= Data_In;
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Frame sequencer: walks pad/data phases and registers the output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            col_r        <= COL_ZERO;
            row_r        <= ROW_ZERO;
            data_out_r   <= ZERO_WORD;
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            data_out_r   <= ZERO_WORD;
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    col_r <= COL_ZERO;
                    row_r <= ROW_ZERO;
                    if (!fifo_empty_s) begin
                        state_r <= (PAD > 0) ? PAD_TOP : ROW_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PAD_TOP: begin
                    valid_out_r <= 1'b1;
                    if (col_r == COL_LINE_END) begin
                        col_r <= COL_ZERO;
                        if (row_r == ROW_PAD_END) begin
                            row_r   <= ROW_ZERO;
                            state_r <= ROW_LEFT;
                        end else begin
                            row_r <= row_r + ROW_ONE;
                        end
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                ROW_LEFT: begin
                    valid_out_r <= 1'b1;
                    if (col_r == COL_PAD_END) begin
                        col_r   <= COL_ZERO;
                        state_r <= ROW_DATA;
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                ROW_DATA: begin
                    // an empty FIFO stalls here with counters held
                    if (pop_s) begin
                        valid_out_r <= 1'b1;
                        data_out_r  <= mem_r[rd_ptr_r];
                        if (col_r == COL_DATA_END) begin
                            col_r <= COL_ZERO;
                            if (PAD > 0) begin
                                state_r <= ROW_RIGHT;
                            end else if (row_r == ROW_IMG_END) begin
                                row_r        <= ROW_ZERO;
                                frame_done_r <= 1'b1;
                                state_r      <= IDLE;
                            end else begin
                                row_r <= row_r + ROW_ONE;
                            end
                        end else begin
                            col_r <= col_r + COL_ONE;
                        end
                    end else begin
                        col_r <= col_r;
                    end
                end
                ROW_RIGHT: begin
                    valid_out_r <= 1'b1;
                    if (col_r == COL_PAD_END) begin
                        col_r <= COL_ZERO;
                        if (row_r == ROW_IMG_END) begin
                            row_r   <= ROW_ZERO;
                            state_r <= PAD_BOT;
                        end else begin
                            row_r   <= row_r + ROW_ONE;
                            state_r <= ROW_LEFT;
                        end
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                PAD_BOT: begin
                    valid_out_r <= 1'b1;
                    if (col_r == COL_LINE_END) begin
                        col_r <= COL_ZERO;
                        if (row_r == ROW_PAD_END) begin
                            row_r        <= ROW_ZERO;
                            frame_done_r <= 1'b1;
                            state_r      <= IDLE;
                        end else begin
                            row_r <= row_r + ROW_ONE;
                        end
                    end else begin
                        col_r <= col_r + COL_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    col_r   <= COL_ZERO;
                    row_r   <= ROW_ZERO;
                end
            endcase
        end
    end

    assign Data_Out   = data_out_r;
    assign Valid_Out  = valid_out_r;
    assign Frame_Done = frame_done_r;
    assign Overflow   = overflow_r;

endmodule

// File: tb/tb_zero_pad_stream.sv
// Directed bench for zero_pad_stream on 3x3 frames: PAD=1 (main), PAD=3 with a
// 4-entry FIFO (overflow), and PAD=0 (pass-through).
`timescale 1ns/1ps
module tb_zero_pad_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // edge counter: after posedge n, cyc == n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // main instance: W=H=3, PAD=1, FIFO 32
    logic        rst_a = 1'b1, vin_a = 1'b0, vout_a, fd_a, ovf_a;
    logic [31:0] din_a = 32'h0, dout_a;
    zero_pad_stream #(.DATA_WIDHT(32), .IMG_WIDHT(3), .IMG_HEIGHT(3), .PAD(1), .FIFO_DEPTH(32)) dut_a (
        .clk(clk), .rst(rst_a), .Data_In(din_a), .Valid_In(vin_a),
        .Data_Out(dout_a), .Valid_Out(vout_a), .Frame_Done(fd_a), .Overflow(ovf_a));

    // overflow instance: W=H=3, PAD=3, FIFO 4
    logic        rst_b = 1'b1, vin_b = 1'b0, vout_b, fd_b, ovf_b;
    logic [31:0] din_b = 32'h0, dout_b;
    zero_pad_stream #(.DATA_WIDHT(32), .IMG_WIDHT(3), .IMG_HEIGHT(3), .PAD(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .Data_In(din_b), .Valid_In(vin_b),
        .Data_Out(dout_b), .Valid_Out(vout_b), .Frame_Done(fd_b), .Overflow(ovf_b));

    // pass-through instance: W=H=3, PAD=0
    logic        rst_c = 1'b1, vin_c = 1'b0, vout_c, fd_c, ovf_c;
    logic [31:0] din_c = 32'h0, dout_c;
    zero_pad_stream #(.DATA_WIDHT(32), .IMG_WIDHT(3), .IMG_HEIGHT(3), .PAD(0), .FIFO_DEPTH(32)) dut_c (
        .clk(clk), .rst(rst_c), .Data_In(din_c), .Valid_In(vin_c),
        .Data_Out(dout_c), .Valid_Out(vout_c), .Frame_Done(fd_c), .Overflow(ovf_c));

    // output logs, sampled on the falling edge
    logic [31:0] a_data[$];
    int          a_edge[$];
    bit          a_fd[$];
    int          a_fd_stray = 0;
    logic [31:0] c_data[$];
    int          c_edge[$];
    bit          c_fd[$];
    int          b_ovf_edge = -1;

    always @(negedge clk) begin
        if (vout_a === 1'b1) begin
            a_data.push_back(dout_a); a_edge.push_back(cyc); a_fd.push_back(fd_a);
        end else if (fd_a === 1'b1) begin
            a_fd_stray++;
        end
        if (vout_c === 1'b1) begin
            c_data.push_back(dout_c); c_edge.push_back(cyc); c_fd.push_back(fd_c);
        end
        if (ovf_b === 1'b1 && b_ovf_edge < 0) b_ovf_edge = cyc;
    end

    // expected stream model
    logic [31:0] exp_q[$];
    bit          exp_fd[$];
    bit          exp_isdata[$];
    int          in_edge = 0;

    task automatic add_frame(input int base, input int pad);
        int n;
        n = 3 + 2 * pad;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (r < pad || r >= pad + 3 || c < pad || c >= pad + 3) begin
                    exp_q.push_back(32'h0); exp_isdata.push_back(1'b0);
                end else begin
                    exp_q.push_back(32'(base + (r - pad) * 3 + (c - pad) + 1)); exp_isdata.push_back(1'b1);
                end
                exp_fd.push_back((r == n - 1) && (c == n - 1));
            end
        end
    endtask

    task automatic clear_logs;
        a_data.delete(); a_edge.delete(); a_fd.delete(); a_fd_stray = 0;
        c_data.delete(); c_edge.delete(); c_fd.delete();
        exp_q.delete(); exp_fd.delete(); exp_isdata.delete();
    endtask

    task automatic reset_a;
        rst_a = 1'b1; vin_a = 1'b0; din_a = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        clear_logs();
    endtask

    task automatic send_a(input logic [31:0] val);
        @(posedge clk); #1;
        din_a = val; vin_a = 1'b1; in_edge = cyc + 1;
    endtask

    task automatic idle_a(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1; vin_a = 1'b0; din_a = 32'h0;
        end
    endtask

    task automatic wait_a(input int n);
        for (int k = 0; k < 400 && a_data.size() < n; k++) @(posedge clk);
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({dout_a, vout_a, fd_a, ovf_a} !== 35'h0) begin failures++; $display("FAIL reset_a: got %09h expected 0", {dout_a, vout_a, fd_a, ovf_a}); end
        checks++; if ({dout_b, vout_b, fd_b, ovf_b} !== 35'h0) begin failures++; $display("FAIL reset_b: got %09h expected 0", {dout_b, vout_b, fd_b, ovf_b}); end
        checks++; if ({dout_c, vout_c, fd_c, ovf_c} !== 35'h0) begin failures++; $display("FAIL reset_c: got %09h expected 0", {dout_c, vout_c, fd_c, ovf_c}); end
        rst_b = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_basic_frame;
        int first_in;
        reset_a();
        add_frame(0, 1);
        for (int i = 1; i <= 9; i++) begin
            send_a(32'(i));
            if (i == 1) first_in = in_edge;
        end
        idle_a(1);
        wait_a(25);
        checks++; if (a_data.size() != 25) begin failures++; $display("FAIL basic_count: got %0d expected 25", a_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= a_data.size()) begin failures++; $display("FAIL basic_word[%0d]: got missing expected %08h", i, exp_q[i]); end
            else if (a_data[i] !== exp_q[i] || a_fd[i] !== exp_fd[i]) begin
                failures++; $display("FAIL basic_word[%0d]: got %08h done=%0b expected %08h done=%0b", i, a_data[i], a_fd[i], exp_q[i], exp_fd[i]);
            end
        end
        checks++; if (a_edge.size() == 0 || a_edge[0] - first_in != 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", (a_edge.size() == 0) ? -1 : a_edge[0] - first_in); end
        checks++; if (a_fd_stray != 0) begin failures++; $display("FAIL basic_stray_done: got %0d expected 0", a_fd_stray); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %0b expected 0", ovf_a); end
    endtask

    task automatic test_input_gap(input int gap, input bit need_stall);
        int bad_gaps, stalls;
        reset_a();
        add_frame(0, 1);
        for (int i = 1; i <= 9; i++) begin
            if (i == 5) idle_a(gap);
            send_a(32'(i));
        end
        idle_a(1);
        wait_a(25);
        checks++; if (a_data.size() != 25) begin failures++; $display("FAIL gap%0d_count: got %0d expected 25", gap, a_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= a_data.size()) begin failures++; $display("FAIL gap%0d_word[%0d]: got missing expected %08h", gap, i, exp_q[i]); end
            else if (a_data[i] !== exp_q[i] || a_fd[i] !== exp_fd[i]) begin
                failures++; $display("FAIL gap%0d_word[%0d]: got %08h done=%0b expected %08h done=%0b", gap, i, a_data[i], a_fd[i], exp_q[i], exp_fd[i]);
            end
        end
        // a hole in Valid_Out may only precede a data word
        bad_gaps = 0; stalls = 0;
        for (int i = 1; i < a_edge.size() && i < exp_isdata.size(); i++) begin
            if (a_edge[i] - a_edge[i-1] != 1) begin
                stalls++;
                if (!exp_isdata[i]) bad_gaps++;
            end
        end
        checks++; if (bad_gaps != 0) begin failures++; $display("FAIL gap%0d_pad_stall: got %0d expected 0", gap, bad_gaps); end
        if (need_stall) begin
            checks++; if (stalls == 0) begin failures++; $display("FAIL gap%0d_stall_seen: got %0d expected >0", gap, stalls); end
        end
    endtask

    task automatic test_back_to_back;
        int w;
        reset_a();
        add_frame(0, 1);
        add_frame(10, 1);
        w = 0;
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 3; k++) begin
                send_a((w < 9) ? 32'(w + 1) : 32'(w + 2));
                w++;
            end
            idle_a(2);
        end
        wait_a(50);
        checks++; if (a_data.size() != 50) begin failures++; $display("FAIL b2b_count: got %0d expected 50", a_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= a_data.size()) begin failures++; $display("FAIL b2b_word[%0d]: got missing expected %08h", i, exp_q[i]); end
            else if (a_data[i] !== exp_q[i] || a_fd[i] !== exp_fd[i]) begin
                failures++; $display("FAIL b2b_word[%0d]: got %08h done=%0b expected %08h done=%0b", i, a_data[i], a_fd[i], exp_q[i], exp_fd[i]);
            end
        end
        checks++; if (a_edge.size() < 26 || a_edge[25] - a_edge[24] != 2) begin failures++; $display("FAIL b2b_idle_gap: got %0d expected 2", (a_edge.size() < 26) ? -1 : a_edge[25] - a_edge[24]); end
        checks++; if (a_fd_stray != 0) begin failures++; $display("FAIL b2b_stray_done: got %0d expected 0", a_fd_stray); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %0b expected 0", ovf_a); end
    endtask

    task automatic test_overflow;
        int fifth_in;
        rst_b = 1'b1; repeat (2) @(posedge clk); #1 rst_b = 1'b0;
        b_ovf_edge = -1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            din_b = 32'(i); vin_b = 1'b1;
            if (i == 5) fifth_in = cyc + 1;
        end
        @(posedge clk); #1 vin_b = 1'b0; din_b = 32'h0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (b_ovf_edge != fifth_in) begin failures++; $display("FAIL ovf_rise_edge: got %0d expected %0d", b_ovf_edge, fifth_in); end
        checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b expected 1", ovf_b); end
        checks++; if (vout_b !== 1'b1) begin failures++; $display("FAIL ovf_pad_active: got %0b expected 1", vout_b); end
        #2 rst_b = 1'b1;
        #1;
        checks++; if ({dout_b, vout_b, fd_b, ovf_b} !== 35'h0) begin failures++; $display("FAIL ovf_async_reset: got %09h expected 0", {dout_b, vout_b, fd_b, ovf_b}); end
        @(posedge clk); #1 rst_b = 1'b0;
    endtask

    task automatic test_no_pad;
        int first_in;
        rst_c = 1'b1; repeat (2) @(posedge clk); #1 rst_c = 1'b0;
        clear_logs();
        add_frame(0, 0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            din_c = 32'(i); vin_c = 1'b1;
            if (i == 1) first_in = cyc + 1;
        end
        @(posedge clk); #1 vin_c = 1'b0; din_c = 32'h0;
        for (int k = 0; k < 200 && c_data.size() < 9; k++) @(posedge clk);
        repeat (6) @(posedge clk);
        checks++; if (c_data.size() != 9) begin failures++; $display("FAIL nopad_count: got %0d expected 9", c_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= c_data.size()) begin failures++; $display("FAIL nopad_word[%0d]: got missing expected %08h", i, exp_q[i]); end
            else if (c_data[i] !== exp_q[i] || c_fd[i] !== exp_fd[i]) begin
                failures++; $display("FAIL nopad_word[%0d]: got %08h done=%0b expected %08h done=%0b", i, c_data[i], c_fd[i], exp_q[i], exp_fd[i]);
            end
        end
        checks++; if (c_edge.size() == 0 || c_edge[0] - first_in != 2) begin failures++; $display("FAIL nopad_latency: got %0d expected 2", (c_edge.size() == 0) ? -1 : c_edge[0] - first_in); end
    endtask

    task automatic test_mid_frame_reset;
        reset_a();
        for (int i = 1; i <= 9; i++) send_a(32'(i));
        idle_a(1);
        for (int k = 0; k < 200 && a_data.size() < 12; k++) @(posedge clk);
        #1;
        checks++; if (vout_a !== 1'b1) begin failures++; $display("FAIL midrst_active: got %0b expected 1", vout_a); end
        #2 rst_a = 1'b1;
        #1;
        checks++; if ({dout_a, vout_a, fd_a, ovf_a} !== 35'h0) begin failures++; $display("FAIL midrst_async: got %09h expected 0", {dout_a, vout_a, fd_a, ovf_a}); end
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        clear_logs();
        add_frame(20, 1);
        for (int i = 21; i <= 29; i++) send_a(32'(i));
        idle_a(1);
        wait_a(25);
        checks++; if (a_data.size() != 25) begin failures++; $display("FAIL midrst_count: got %0d expected 25", a_data.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= a_data.size()) begin failures++; $display("FAIL midrst_word[%0d]: got missing expected %08h", i, exp_q[i]); end
            else if (a_data[i] !== exp_q[i] || a_fd[i] !== exp_fd[i]) begin
                failures++; $display("FAIL midrst_word[%0d]: got %08h done=%0b expected %08h done=%0b", i, a_data[i], a_fd[i], exp_q[i], exp_fd[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_input_gap(5, 1'b0);
        test_input_gap(15, 1'b1);
        test_back_to_back();
        test_overflow();
        test_no_pad();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
